l2_arbiter: RTL and testbench
=============================

# l2_arbiter

Parametrised arbiter that multiplexes NUM_REQ L1 caches (instruction, data, and any future requesters) onto the single L2 port. Each requester issues line-sized reads or writes with a level request held until response. The arbiter registers the winning address and write data, drives one L2 transaction at a time, and returns a registered read line plus a one-cycle response to the granted requester only. It replaces the fixed two-port instruction/data arbiter. It adds a selectable fixed or round-robin policy and fully registered L2 outputs.

## Interface
- NUM_REQ, 2, number of requesters (2..8); index 0 is highest fixed priority.
- ADDR_W, 32, address width.
- LINE_W, 256, cache line width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_read  in  NUM_REQ  per-requester read request, level, held until req_resp.
- req_write  in  NUM_REQ  per-requester write request, level, held until req_resp.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*LINE_W  packed write lines, same packing.
- req_rdata  out  LINE_W  registered read line, broadcast to all requesters.
- req_resp  out  NUM_REQ  one-hot, one-cycle completion pulse.
- l2_addr  out  ADDR_W  registered L2 address (MAR).
- l2_wdata  out  LINE_W  registered L2 write line (MDR out).
- l2_rdata  in  LINE_W  L2 read line, valid with l2_resp.
- l2_read  out  1  L2 read strobe, held until l2_resp.
- l2_write  out  1  L2 write strobe, held until l2_resp.
- l2_resp  in  1  L2 completion.
- grant_id  out  $clog2(NUM_REQ)  index of the current owner; valid while busy.
- busy  out  1  high in ISSUE and RESPOND.

## Operation
- States:
  - IDLE: no transaction owned.
  - ISSUE: L2 strobe driven.
  - RESPOND: one-cycle response to the owner.
- Transitions:
  - IDLE→ISSUE when any (req_read|req_write) bit is set.
  - ISSUE→RESPOND on l2_resp.
  - RESPOND→IDLE unconditionally.
- Grant in IDLE:
  - Fixed mode: lowest active index.
  - RR mode: first active index searching upward from rr_ptr+1, with wrap-around.
  - rr_ptr updates to the winner on grant; it is unchanged in fixed mode.
- On grant edge, the arbiter captures:
  - l2_addr ← winner's address.
  - l2_wdata ← winner's wdata (writes only; held otherwise).
  - grant_id ← winner.
  - op ← write if req_write[winner], else read. Write takes precedence if both are set.
- ISSUE:
  - l2_write = op, l2_read = !op, both driven from registered state.
  - On l2_resp with a read op, req_rdata ← l2_rdata; on a write op, req_rdata holds.
- RESPOND: req_resp[grant_id] = 1, all other bits 0.
- Request deassertion during ISSUE is ignored: the transaction completes and the response still pulses.
- Requests from non-owners are not sampled until IDLE.

## Timing
- Reset (async):
  - State is IDLE and rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - All outputs are 0: l2_addr, l2_wdata, req_rdata, req_resp, l2_read, l2_write, grant_id, busy.
  - Reset mid-transaction abandons it; no response is issued.
- Request arrives in cycle 0 (IDLE):
  - l2_read/l2_write is high from cycle 1.
  - If l2_resp arrives in cycle k ≥ 1, req_resp is high in cycle k+1 with req_rdata valid.
  - Minimum latency is 2 cycles from request to response.
- The requester drops its request in the cycle after req_resp. The next IDLE cycle (k+2) arbitrates, so one dead cycle always separates transactions.
- The L2 strobe is never asserted in IDLE or RESPOND. At most one of l2_read/l2_write is ever high.
- Simultaneous requests in the same IDLE cycle are resolved by policy. The losers wait with no starvation in RR mode.
- l2_resp outside ISSUE is ignored.

## Test plan
- Reset: hold rst_n=0 mid-ISSUE → all outputs 0 within the same cycle. After release, req_read=01 grants requester 0 first.
- Single read:
  - Stimulus: req_read[1]=1, addr 0x0000_1240, l2_resp in cycle 3 with l2_rdata=0xA5…A5.
  - Response: l2_read high cycles 1–3, l2_addr=0x1240, req_resp=10 in cycle 4, req_rdata=0xA5…A5.
- Single write:
  - Stimulus: req_write[0]=1, wdata=0x0123…EF, l2_resp in cycle 1.
  - Response: l2_write high in cycle 1 only, l2_wdata matches, req_resp=01 in cycle 2, l2_read never high.
- Round-robin fairness: NUM_REQ=4, all read continuously, l2_resp after 1 cycle → grant_id sequence 0,1,2,3,0. Each requester receives exactly one req_resp per 4 transactions.
- Fixed priority (RR_MODE=0): requesters 0 and 2 continuously requesting → requester 0 wins every arbitration; 2 is granted only after 0 stops.
- Edge cases:
  - Read and write set together on one requester → a write is issued.
  - Spurious l2_resp in IDLE → no state change and no req_resp.

Source files
------------

// File: rtl/l2_arbiter.sv
// Shares one L2 port between NUM_REQ L1 requesters, using fixed or round-robin arbitration.
// Each transaction is tracked from grant to response. Every L2-facing and requester-facing output is registered.
module l2_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int RR_MODE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LINE_W-1:0]   req_wdata,
    output logic [LINE_W-1:0]           req_rdata,
    output logic [NUM_REQ-1:0]          req_resp,
    output logic [ADDR_W-1:0]           l2_addr,
    output logic [LINE_W-1:0]           l2_wdata,
    input  logic [LINE_W-1:0]           l2_rdata,
    output logic                        l2_read,
    output logic                        l2_write,
    input  logic                        l2_resp,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESPOND
    } state_t;

    state_t            state_reg;
    logic              op_reg;          // 1 = write
    logic [ID_W-1:0]   rr_ptr_reg;

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [LINE_W-1:0] wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] active;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*LINE_W +: LINE_W];
        end
    endgenerate

    assign active = req_read | req_write;

    // Round-robin: first active index above the pointer, otherwise wrap to the lowest active index
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] lowest_win;
    logic [ID_W-1:0] above_win;
    logic            any_above;

    always_comb begin
        lowest_win = '0;
        above_win  = '0;
        any_above  = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (active[j]) begin
                lowest_win = ID_W'(j);
                if (j > int'(rr_ptr_reg)) begin
                    above_win = ID_W'(j);
                    any_above = 1'b1;
                end
            end
        end
        if ((RR_MODE != 0) && any_above) begin
            winner = above_win;
        end else begin
            winner = lowest_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            op_reg     <= 1'b0;
            rr_ptr_reg <= ID_W'(NUM_REQ - 1);
            req_rdata  <= '0;
            req_resp   <= '0;
            l2_addr    <= '0;
            l2_wdata   <= '0;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    req_resp <= '0;
                    if (|active) begin
                        state_reg <= S_ISSUE;
                        busy      <= 1'b1;
                        grant_id  <= winner;
                        l2_addr   <= addr_arr[winner];
                        op_reg    <= req_write[winner];
                        l2_write  <= req_write[winner];
                        l2_read   <= !req_write[winner];
                        if (req_write[winner]) begin
                            l2_wdata <= wdata_arr[winner];
                        end
                        if (RR_MODE != 0) begin
                            rr_ptr_reg <= winner;
                        end
                    end
                end
                S_ISSUE: begin
                    if (l2_resp) begin
                        state_reg <= S_RESPOND;
                        l2_read   <= 1'b0;
                        l2_write  <= 1'b0;
                        if (!op_reg) begin
                            req_rdata <= l2_rdata;
                        end
                        req_resp <= NUM_REQ'(1) << grant_id;
                    end
                end
                S_RESPOND: begin
                    state_reg <= S_IDLE;
                    req_resp  <= '0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    req_resp  <= '0;
                    busy      <= 1'b0;
                    l2_read   <= 1'b0;
                    l2_write  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: one round-robin instance and one fixed-priority instance.
// A transaction-level model is compared with the DUT outputs on every cycle.
module tb_l2_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int IW = 2;
    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_RESP  = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic [N-1:0]    rd        [2];
    logic [N-1:0]    wr        [2];
    logic [N*AW-1:0] addr      [2];
    logic [N*LW-1:0] wdata     [2];
    logic [LW-1:0]   l2_rdata  [2];
    logic            l2_resp   [2];
    logic [LW-1:0]   req_rdata [2];
    logic [N-1:0]    req_resp  [2];
    logic [AW-1:0]   l2_addr   [2];
    logic [LW-1:0]   l2_wdata  [2];
    logic            l2_read   [2];
    logic            l2_write  [2];
    logic            busy      [2];
    logic [IW-1:0]   grant_id  [2];

    // model state and expected outputs
    int            m_ph   [2];
    logic          m_op   [2];
    int            m_ptr  [2];
    logic [AW-1:0] e_addr [2];
    logic [LW-1:0] e_wdata[2];
    logic [LW-1:0] e_rdata[2];
    logic [N-1:0]  e_resp [2];
    logic          e_read [2];
    logic          e_write[2];
    logic          e_busy [2];
    logic [IW-1:0] e_gid  [2];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    l2_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_read(rd[0]), .req_write(wr[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
        .req_rdata(req_rdata[0]), .req_resp(req_resp[0]),
        .l2_addr(l2_addr[0]), .l2_wdata(l2_wdata[0]), .l2_rdata(l2_rdata[0]),
        .l2_read(l2_read[0]), .l2_write(l2_write[0]), .l2_resp(l2_resp[0]),
        .grant_id(grant_id[0]), .busy(busy[0])
    );

    l2_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .req_read(rd[1]), .req_write(wr[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
        .req_rdata(req_rdata[1]), .req_resp(req_resp[1]),
        .l2_addr(l2_addr[1]), .l2_wdata(l2_wdata[1]), .l2_rdata(l2_rdata[1]),
        .l2_read(l2_read[1]), .l2_write(l2_write[1]), .l2_resp(l2_resp[1]),
        .grant_id(grant_id[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] act, input int ptr, input bit rr);
        if (!rr) begin
            for (int i = 0; i < N; i++) if (act[i]) return i;
        end else begin
            for (int d = 1; d <= N; d++) if (act[(ptr + d) % N]) return (ptr + d) % N;
        end
        return -1;
    endfunction

    task automatic m_reset(input int k);
        m_ph[k]    = P_IDLE;
        m_op[k]    = 1'b0;
        m_ptr[k]   = N - 1;
        e_addr[k]  = '0;
        e_wdata[k] = '0;
        e_rdata[k] = '0;
        e_resp[k]  = '0;
        e_read[k]  = 1'b0;
        e_write[k] = 1'b0;
        e_busy[k]  = 1'b0;
        e_gid[k]   = '0;
    endtask

    // behavioural model: advances one transaction phase per clock
    initial begin
        int w;
        m_reset(0);
        m_reset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    m_reset(k);
                end else if (m_ph[k] == P_IDLE) begin
                    e_resp[k] = '0;
                    w = pick(rd[k] | wr[k], m_ptr[k], k == 0);
                    if (w >= 0) begin
                        m_ph[k]    = P_ISSUE;
                        e_busy[k]  = 1'b1;
                        e_gid[k]   = IW'(w);
                        e_addr[k]  = addr[k][w*AW +: AW];
                        m_op[k]    = wr[k][w];
                        e_write[k] = m_op[k];
                        e_read[k]  = !m_op[k];
                        if (m_op[k]) e_wdata[k] = wdata[k][w*LW +: LW];
                        if (k == 0) m_ptr[k] = w;
                    end
                end else if (m_ph[k] == P_ISSUE) begin
                    if (l2_resp[k]) begin
                        m_ph[k]    = P_RESP;
                        e_read[k]  = 1'b0;
                        e_write[k] = 1'b0;
                        if (!m_op[k]) e_rdata[k] = l2_rdata[k];
                        e_resp[k]  = '0;
                        e_resp[k][e_gid[k]] = 1'b1;
                    end
                end else begin
                    m_ph[k]   = P_IDLE;
                    e_resp[k] = '0;
                    e_busy[k] = 1'b0;
                end
            end
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy[%0d]", k), busy[k], e_busy[k]);
                chk($sformatf("l2_read[%0d]", k), l2_read[k], e_read[k]);
                chk($sformatf("l2_write[%0d]", k), l2_write[k], e_write[k]);
                chk($sformatf("req_resp[%0d]", k), req_resp[k], e_resp[k]);
                chk($sformatf("req_rdata[%0d]", k), req_rdata[k], e_rdata[k]);
                chk($sformatf("l2_addr[%0d]", k), l2_addr[k], e_addr[k]);
                chk($sformatf("l2_wdata[%0d]", k), l2_wdata[k], e_wdata[k]);
                if (e_busy[k]) chk($sformatf("grant_id[%0d]", k), grant_id[k], e_gid[k]);
                if (|e_resp[k]) $display("inst %0d txn owner %0d %s", k, e_gid[k], m_op[k] ? "write" : "read");
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [IW-1:0] rr_seq  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [N-1:0]  rr_resp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [LW-1:0] a5_line;
    logic [LW-1:0] wpat;
    logic [N-1:0]  quiet [2];

    initial begin
        int op;
        a5_line = {8{32'hA5A5A5A5}};
        wpat    = {4{64'h0123456789ABCDEF}};
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd[k] = '0; wr[k] = '0; addr[k] = '0; wdata[k] = '0;
            l2_rdata[k] = '0; l2_resp[k] = 1'b0; quiet[k] = '0;
        end
        step(3);
        chk("reset_busy", busy[0], 1'b0);
        chk("reset_ptr_pair", {req_resp[0], grant_id[0]}, '0);
        rst_n = 1'b1;
        step(1);

        // round-robin fairness: all four read continuously, L2 answers immediately
        rd[0] = 4'hF;
        l2_resp[0] = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step(1);
            chk("rr_grant", grant_id[0], rr_seq[t]);
            step(1);
            chk("rr_resp", req_resp[0], rr_resp[t]);
            if (t == 4) begin
                rd[0] = '0;
                l2_resp[0] = 1'b0;
            end
            step(1);
        end

        // single read from requester 1, L2 answers in cycle 3
        rd[0][1] = 1'b1;
        addr[0][AW +: AW] = 32'h0000_1240;
        chk("rd_idle_busy", busy[0], 1'b0);
        step(1);
        chk("rd_c1_read", l2_read[0], 1'b1);
        chk("rd_c1_addr", l2_addr[0], 32'h0000_1240);
        step(1);
        chk("rd_c2_read", l2_read[0], 1'b1);
        step(1);
        chk("rd_c3_read", l2_read[0], 1'b1);
        l2_resp[0] = 1'b1;
        l2_rdata[0] = a5_line;
        step(1);
        l2_resp[0] = 1'b0;
        rd[0][1] = 1'b0;
        chk("rd_c4_resp", req_resp[0], 4'b0010);
        chk("rd_c4_rdata", req_rdata[0], a5_line);
        chk("rd_c4_read", l2_read[0], 1'b0);
        step(1);
        chk("rd_c5_resp", req_resp[0], 4'b0000);

        // single write from requester 0, L2 answers in cycle 1
        wr[0][0] = 1'b1;
        wdata[0][0 +: LW] = wpat;
        step(1);
        chk("wr_c1_write", l2_write[0], 1'b1);
        chk("wr_c1_read", l2_read[0], 1'b0);
        chk("wr_c1_wdata", l2_wdata[0], wpat);
        l2_resp[0] = 1'b1;
        step(1);
        l2_resp[0] = 1'b0;
        wr[0][0] = 1'b0;
        chk("wr_c2_resp", req_resp[0], 4'b0001);
        chk("wr_c2_write", l2_write[0], 1'b0);
        chk("wr_c2_rdata_held", req_rdata[0], a5_line);
        step(1);

        // read and write together on requester 2 issue a write
        rd[0][2] = 1'b1;
        wr[0][2] = 1'b1;
        wdata[0][2*LW +: LW] = ~wpat;
        step(1);
        chk("rw_write", l2_write[0], 1'b1);
        chk("rw_read", l2_read[0], 1'b0);
        chk("rw_grant", grant_id[0], 2'd2);
        l2_resp[0] = 1'b1;
        step(1);
        l2_resp[0] = 1'b0;
        rd[0][2] = 1'b0;
        wr[0][2] = 1'b0;
        step(1);

        // reset mid-ISSUE, then requester 0 must win first
        rd[0][1] = 1'b1;
        step(2);
        chk("pre_reset_busy", busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_read", l2_read[0], 1'b0);
        chk("rst_addr", l2_addr[0], '0);
        chk("rst_wdata", l2_wdata[0], '0);
        chk("rst_rdata", req_rdata[0], '0);
        chk("rst_gid", grant_id[0], '0);
        rd[0] = '0;
        step(1);
        rst_n = 1'b1;
        rd[0] = 4'b1001;
        step(1);
        chk("post_rst_grant", grant_id[0], 2'd0);
        l2_resp[0] = 1'b1;
        step(1);
        rd[0] = '0;
        l2_resp[0] = 1'b0;
        chk("post_rst_resp", req_resp[0], 4'b0001);
        step(1);

        // spurious l2_resp while idle
        l2_resp[0] = 1'b1;
        step(2);
        chk("spur_busy", busy[0], 1'b0);
        chk("spur_resp", req_resp[0], 4'b0000);
        l2_resp[0] = 1'b0;
        step(1);

        // fixed priority: 0 and 2 request, 0 always wins until it stops
        rd[1] = 4'b0101;
        l2_resp[1] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step(1);
            chk("fx_grant0", grant_id[1], 2'd0);
            step(1);
            chk("fx_resp0", req_resp[1], 4'b0001);
            if (t == 2) rd[1][0] = 1'b0;
            step(1);
        end
        step(1);
        chk("fx_grant2", grant_id[1], 2'd2);
        rd[1] = '0;
        step(1);
        chk("fx_resp2", req_resp[1], 4'b0100);
        l2_resp[1] = 1'b0;
        step(1);

        // randomized traffic on both instances
        for (int c = 0; c < 4000; c++) begin
            step(1);
            for (int k = 0; k < 2; k++) begin
                l2_resp[k] = ($urandom_range(0, 2) == 0);
                for (int w = 0; w < LW / 32; w++) l2_rdata[k][w*32 +: 32] = $urandom;
                for (int i = 0; i < N; i++) begin
                    if (e_resp[k][i]) begin
                        rd[k][i] = 1'b0;
                        wr[k][i] = 1'b0;
                        quiet[k][i] = 1'b0;
                    end else if (m_ph[k] == P_ISSUE && int'(e_gid[k]) == i &&
                                 (rd[k][i] | wr[k][i]) && $urandom_range(0, 15) == 0) begin
                        rd[k][i] = 1'b0;
                        wr[k][i] = 1'b0;
                        quiet[k][i] = 1'b1;
                    end else if (!(rd[k][i] | wr[k][i]) && !quiet[k][i] && $urandom_range(0, 3) == 0) begin
                        op = int'($urandom_range(0, 2));
                        rd[k][i] = (op != 1);
                        wr[k][i] = (op != 0);
                        addr[k][i*AW +: AW] = $urandom;
                        for (int w = 0; w < LW / 32; w++) wdata[k][i*LW + w*32 +: 32] = $urandom;
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            rd[k] = '0;
            wr[k] = '0;
            l2_resp[k] = 1'b1;
        end
        step(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
